// File: rtl/adc_clkgen_div_if.sv
// Configuration handshake bundle for adc_clkgen_div.
// The master requests a new divide/phase for one channel; the slave
// reports slot availability (cfg_ready) and rejected requests (cfg_err).
interface adc_clkgen_div_if #(
  parameter int NUM_CH = 6,
  parameter int DIV_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_phase,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_phase,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/adc_clkgen_div.sv
// adc_clkgen_div: multi-channel programmable clock/strobe divider on refclk.
// Each channel counts 0..div-1; outclk is high for the first div/2 counts,
// outstb pulses on count 0. Divide/phase updates are held pending and applied
// at the target channel's wrap so the output never glitches. A lock FSM
// reports LOCKED after LOCK_CYCLES consecutive undisturbed enabled cycles.
// Optional build macro CLKGEN_SYNC_ALIGN_EN adds a sync_in port that realigns
// every channel to its last applied phase.
module adc_clkgen_div #(
  parameter int NUM_CH      = 6,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 64
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              enable,
`ifdef CLKGEN_SYNC_ALIGN_EN
  input  logic              sync_in,
`endif
  adc_clkgen_div_if.slave   cfg,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] outstb,
  output logic              locked
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SET_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

  localparam logic [0:0] SETTLE = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [DIV_W-1:0] cnt_q   [NUM_CH];
  logic [DIV_W-1:0] div_q   [NUM_CH];
  logic [DIV_W-1:0] phase_q [NUM_CH];
  logic [DIV_W-1:0] cnt_d   [NUM_CH];
  logic [DIV_W-1:0] div_d   [NUM_CH];
  logic [DIV_W-1:0] phase_d [NUM_CH];

  logic             pend_vld;
  logic [CH_W-1:0]  pend_ch;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] pend_phase;

  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] sel;
  logic              sync_hit;
  logic              apply_now;
  logic              req_take;
  logic              req_bad;

  logic [0:0]       state_q;
  logic [SET_W-1:0] settle_q;

  assign cfg.cfg_ready = ~pend_vld;
  assign locked        = (state_q == LOCKED);

  assign req_take = cfg.cfg_valid & ~pend_vld;
  assign req_bad  = (cfg.cfg_div < DIV_W'(2)) || ({1'b0, cfg.cfg_ch} >= NUM_CH_L);

  // Next count/divide/phase per channel: realign, apply pending, or free-run.
  always_comb begin
    sync_hit = 1'b0;
`ifdef CLKGEN_SYNC_ALIGN_EN
    sync_hit = enable & sync_in;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i] = (cnt_q[i] == (div_q[i] - DIV_W'(1)));
      sel[i]  = pend_vld && (pend_ch == CH_W'(i));
    end
    apply_now = enable && pend_vld && (sync_hit || |(wrap & sel));
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i]   = div_q[i];
      phase_d[i] = phase_q[i];
      cnt_d[i]   = cnt_q[i];
      if (apply_now && sel[i]) begin
        div_d[i]   = pend_div;
        phase_d[i] = pend_phase;
      end
      if (sync_hit) begin
        cnt_d[i] = phase_d[i];
      end else if (enable) begin
        if (apply_now && sel[i]) begin
          cnt_d[i] = pend_phase;
        end else if (wrap[i]) begin
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
      end
    end
  end

  // Channel state and registered outputs derived from the new count.
  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]   <= DIV_W'(1);
        div_q[i]   <= DIV_W'(2);
        phase_q[i] <= '0;
      end
      outclk <= '0;
      outstb <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        div_q[i]   <= div_d[i];
        phase_q[i] <= phase_d[i];
        if (enable) begin
          outclk[i] <= (cnt_d[i] < (div_d[i] >> 1));
          outstb[i] <= (cnt_d[i] == '0);
        end else begin
          outstb[i] <= 1'b0;
        end
      end
    end
  end

  // Pending-slot control and one-cycle rejection pulse.
  always_ff @(posedge refclk) begin
    if (rst) begin
      pend_vld    <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= req_take & req_bad;
      if (apply_now) begin
        pend_vld <= 1'b0;
      end else if (req_take && !req_bad) begin
        pend_vld <= 1'b1;
      end
    end
  end

  // Pending request payload; out-of-range phase is folded to 0 on capture.
  always_ff @(posedge refclk) begin
    if (req_take && !req_bad) begin
      pend_ch    <= cfg.cfg_ch;
      pend_div   <= cfg.cfg_div;
      pend_phase <= (cfg.cfg_phase < cfg.cfg_div) ? cfg.cfg_phase : '0;
    end
  end

  // Lock FSM: any disturbance restarts the settle interval.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q  <= SETTLE;
      settle_q <= '0;
    end else if (!enable || apply_now || sync_hit) begin
      state_q  <= SETTLE;
      settle_q <= '0;
    end else if (state_q == SETTLE) begin
      settle_q <= settle_q + SET_W'(1);
      if (settle_q + SET_W'(1) == SET_W'(LOCK_CYCLES)) begin
        state_q <= LOCKED;
      end
    end
  end

endmodule

// File: tb/tb_adc_clkgen_div.sv
// Self-checking bench for adc_clkgen_div: directed table of config requests,
// hand-written multi-cycle sequences, and randomized traffic checked every
// cycle against a modulo-arithmetic reference model.
module tb_adc_clkgen_div;
  localparam int NUM_CH      = 6;
  localparam int DIV_W       = 16;
  localparam int LOCK_CYCLES = 64;
  localparam int CH_W        = 3;

  logic refclk = 1'b0;
  logic rst;
  logic enable;
`ifdef CLKGEN_SYNC_ALIGN_EN
  logic sync_in;
`endif
  logic [NUM_CH-1:0] outclk;
  logic [NUM_CH-1:0] outstb;
  logic              locked;

  adc_clkgen_div_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) cfg_if ();

  adc_clkgen_div #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES)) dut (
    .refclk (refclk),
    .rst    (rst),
    .enable (enable),
`ifdef CLKGEN_SYNC_ALIGN_EN
    .sync_in(sync_in),
`endif
    .cfg    (cfg_if),
    .outclk (outclk),
    .outstb (outstb),
    .locked (locked)
  );

  always #5 refclk = ~refclk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_cnt [NUM_CH];
  int m_div [NUM_CH];
  int m_ph  [NUM_CH];
  logic [NUM_CH-1:0] m_clk = '0;
  logic [NUM_CH-1:0] m_stb = '0;
  bit m_pv = 0, m_err = 0, m_locked = 0;
  int m_pch = 0, m_pdiv = 0, m_pph = 0, m_run = 0;

  typedef struct {
    int ch; int dv; int ph; bit exp_err; int exp_first; int exp_period; int exp_high;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit sync_now();
`ifdef CLKGEN_SYNC_ALIGN_EN
    return sync_in;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_tick();
    bit s, apply, take;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_cnt[i] = 1; m_div[i] = 2; m_ph[i] = 0;
      end
      m_clk = '0; m_stb = '0; m_pv = 0; m_err = 0; m_locked = 0; m_run = 0;
      return;
    end
    s = enable && sync_now();
    apply = enable && m_pv && (s || (m_cnt[m_pch] == m_div[m_pch] - 1));
    take = cfg_if.cfg_valid && !m_pv;
    m_err = take && ((int'(cfg_if.cfg_div) < 2) || (int'(cfg_if.cfg_ch) >= NUM_CH));
    for (int i = 0; i < NUM_CH; i++) begin
      if (apply && i == m_pch) begin
        m_div[i] = m_pdiv; m_ph[i] = m_pph;
      end
      if (s) m_cnt[i] = m_ph[i];
      else if (enable) begin
        if (apply && i == m_pch) m_cnt[i] = m_pph;
        else m_cnt[i] = (m_cnt[i] + 1) % m_div[i];
      end
      if (enable) begin
        m_clk[i] = (m_cnt[i] < m_div[i] / 2);
        m_stb[i] = (m_cnt[i] == 0);
      end else begin
        m_stb[i] = 1'b0;
      end
    end
    if (apply) m_pv = 0;
    else if (take && !m_err) begin
      m_pv = 1; m_pch = int'(cfg_if.cfg_ch); m_pdiv = int'(cfg_if.cfg_div);
      m_pph = (int'(cfg_if.cfg_phase) < m_pdiv) ? int'(cfg_if.cfg_phase) : 0;
    end
    if (!enable || apply || s) begin
      m_run = 0; m_locked = 0;
    end else begin
      m_run++;
      if (m_run >= LOCK_CYCLES) m_locked = 1;
    end
  endtask

  task automatic step();
    @(posedge refclk);
    model_tick();
    #1;
    chk("model_outclk", outclk, m_clk);
    chk("model_outstb", outstb, m_stb);
    chk("model_locked", locked, m_locked);
    chk("model_ready", cfg_if.cfg_ready, !m_pv);
    chk("model_err", cfg_if.cfg_err, m_err);
  endtask

  task automatic send_cfg(input int ch, input int dv, input int ph);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = CH_W'(ch);
    cfg_if.cfg_div   = DIV_W'(dv);
    cfg_if.cfg_phase = DIV_W'(ph);
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!cfg_if.cfg_ready && n < 200) begin step(); n++; end
    chk(name, cfg_if.cfg_ready, 1);
  endtask

  initial begin
    int n, hi, ch;
    tbl[0] = '{3, 10, 0, 1'b0, 0, 10, 5};
    tbl[1] = '{0,  7, 3, 1'b0, 4,  7, 3};
    tbl[2] = '{2,  1, 0, 1'b1, 0,  0, 0};
    tbl[3] = '{NUM_CH, 4, 0, 1'b1, 0, 0, 0};
    tbl[4] = '{2,  5, 9, 1'b0, 0,  5, 2};

    rst = 1'b1; enable = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0; cfg_if.cfg_phase = '0;
`ifdef CLKGEN_SYNC_ALIGN_EN
    sync_in = 1'b0;
`endif

    // Reset state
    repeat (4) step();
    chk("rst_outclk", outclk, 0);
    chk("rst_outstb", outstb, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ready", cfg_if.cfg_ready, 1);
    chk("rst_err", cfg_if.cfg_err, 0);

    // Free-run at div 2 and lock after LOCK_CYCLES enabled cycles
    rst = 1'b0; enable = 1'b1;
    for (int k = 1; k <= LOCK_CYCLES; k++) begin
      step();
      if (k == 1) begin
        chk("first_stb", outstb, {NUM_CH{1'b1}});
        chk("first_clk", outclk, {NUM_CH{1'b1}});
      end
      if (k == 2) begin
        chk("toggle_stb", outstb, 0);
        chk("toggle_clk", outclk, 0);
      end
      if (k == LOCK_CYCLES - 1) chk("lock_early", locked, 0);
    end
    chk("lock_at_64", locked, 1);

    // Table-driven config requests
    for (int v = 0; v < 5; v++) begin
      ch = (tbl[v].ch < NUM_CH) ? tbl[v].ch : 0;
      send_cfg(tbl[v].ch, tbl[v].dv, tbl[v].ph);
      chk("tbl_err", cfg_if.cfg_err, tbl[v].exp_err);
      if (tbl[v].exp_err) begin
        chk("tbl_ready_kept", cfg_if.cfg_ready, 1);
        chk("tbl_lock_kept", locked, 1);
        step();
        chk("tbl_err_once", cfg_if.cfg_err, 0);
        chk("tbl_lock_after", locked, 1);
      end else begin
        chk("tbl_ready_low", cfg_if.cfg_ready, 0);
        wait_ready("tbl_apply_seen");
        n = 0;
        while (!outstb[ch] && n < 100) begin step(); n++; end
        chk("tbl_first_stb", n, tbl[v].exp_first);
        hi = 0; n = 0;
        do begin
          if (outclk[ch]) hi++;
          step(); n++;
        end while (!outstb[ch] && n < 100);
        chk("tbl_period", n, tbl[v].exp_period);
        chk("tbl_high", hi, tbl[v].exp_high);
        repeat (LOCK_CYCLES + 2) step();
        chk("tbl_relock", locked, 1);
      end
    end

    // Pending request dropped by reset while enable is low
    send_cfg(1, 20, 0);
    chk("hold_ready_low", cfg_if.cfg_ready, 0);
    enable = 1'b0;
    repeat (50) step();
    chk("hold_no_apply", cfg_if.cfg_ready, 0);
    chk("hold_unlocked", locked, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_ready", cfg_if.cfg_ready, 1);
    chk("rst_mid_locked", locked, 0);
    enable = 1'b1;
    step(); chk("rst_mid_stb_a", outstb[1], 1);
    step(); chk("rst_mid_stb_b", outstb[1], 0);
    step(); chk("rst_mid_stb_c", outstb[1], 1);
    chk("rst_mid_ready2", cfg_if.cfg_ready, 1);

`ifdef CLKGEN_SYNC_ALIGN_EN
    // Realignment to stored phases
    send_cfg(0, 8, 0); wait_ready("sync_cfg0");
    send_cfg(1, 8, 2); wait_ready("sync_cfg1");
    repeat (LOCK_CYCLES + 2) step();
    chk("sync_prelock", locked, 1);
    repeat (3) step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    chk("sync_stb0", outstb[0], 1);
    chk("sync_stb1", outstb[1], 0);
    step();
    chk("sync_unlock", locked, 0);
    n = 1;
    while (!outstb[1] && n < 100) begin step(); n++; end
    chk("sync_offset", n, 6);
    n = 0;
    while (!outstb[0] && n < 100) begin step(); n++; end
    chk("sync_offset_b", n, 2);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst    = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 19) != 0);
      cfg_if.cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_if.cfg_ch    = CH_W'($urandom_range(0, NUM_CH));
      cfg_if.cfg_div   = DIV_W'($urandom_range(0, 12));
      cfg_if.cfg_phase = DIV_W'($urandom_range(0, 15));
`ifdef CLKGEN_SYNC_ALIGN_EN
      sync_in = ($urandom_range(0, 59) == 0);
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_clkgen_div.md
Name: adc_clkgen_div

Overview:
- Runtime-programmable, multi-channel clock/strobe generator driven from a single PLL output clock.
- Produces NUM_CH divided square-wave clocks and one-cycle rising-edge strobes for ADC sampling and frame timing.
- Each channel has its own divide ratio and phase offset, updated glitch-free at the channel's period boundary.
- A lock FSM reports when all channels have run stably for a settling interval, matching the locked semantics of the PLL wrappers.

Parameters:
- NUM_CH, 6, number of output channels (1..16).
- DIV_W, 16, width of the divide and phase fields.
- LOCK_CYCLES, 64, enabled cycles of stable operation required before locked asserts (>=2).
- CH_W, $clog2(NUM_CH) (min 1), width of the channel select field; derived, not overridden.

Ports:
- refclk, in, 1, single clock; all logic is on its rising edge.
- rst, in, 1, synchronous active-high reset.
- enable, in, 1, run enable; counters advance only while high.
- cfg_valid, in, 1, configuration request.
- cfg_ready, out, 1, configuration slot free.
- cfg_ch, in, CH_W, target channel.
- cfg_div, in, DIV_W, period in refclk cycles.
- cfg_phase, in, DIV_W, counter preload at apply.
- cfg_err, out, 1, one-cycle pulse when a request is rejected.
- outclk, out, NUM_CH, divided clocks.
- outstb, out, NUM_CH, one-cycle strobe on each outclk period start.
- locked, out, 1, all channels stable.

Behaviour:
- Reset values: cnt[i]=1, div[i]=2, phase[i]=0, outclk=0, outstb=0, locked=0, cfg_ready=1, cfg_err=0, pending discarded, FSM=SETTLE with settle count 0.
- Counter: per channel, cnt[i] in 0..div[i]-1. On an enable-high cycle, cnt[i] goes to 0 if cnt[i]==div[i]-1, otherwise cnt[i]+1. On enable-low cycles, cnt holds.
- Outputs are registered from the new count:
  - outclk[i] = (cnt_next < div[i]>>1), so odd div gives floor(div/2) cycles high.
  - outstb[i] = enable & (cnt_next==0).
  - While enable is low, outclk holds and outstb=0.
  - First strobe appears one cycle after enable first goes high following reset.
- Config handshake:
  - A request is accepted when cfg_valid & cfg_ready.
  - If cfg_div<2 or cfg_ch>=NUM_CH: no state change, cfg_err=1 for one cycle, cfg_ready stays 1.
  - Otherwise the request is stored as pending and cfg_ready drops to 0 on the next cycle.
- Apply:
  - Happens on the first enabled cycle with cnt[ch]==div[ch]-1.
  - That cycle: div[ch]<=cfg_div; cnt_next = (cfg_phase<cfg_div) ? cfg_phase : 0; outstb asserts only if cnt_next==0.
  - cfg_ready returns to 1 the following cycle.
  - Only one request can be pending; other channels are unaffected.
- Lock FSM, states SETTLE and LOCKED:
  - SETTLE: the settle counter increments on enabled cycles. When it reaches LOCK_CYCLES, go to LOCKED and assert locked=1 that cycle+1.
  - LOCKED: locked=1.
  - Any apply, or enable low for one cycle, returns the FSM to SETTLE with counter=0 and locked=0 on the next cycle.
  - A rejected request (cfg_err) does not affect the FSM.
- Simultaneous events: a request presented in the same cycle that a pending request applies is not accepted, because cfg_ready is still 0. rst has priority over everything.
- Reset mid-operation: any pending request is dropped with no apply, and all channels return to div 2.

Optional Feature:
- Macro: CLKGEN_SYNC_ALIGN_EN.
- Defined: adds input port sync_in (1 bit).
  - On an enabled cycle with sync_in=1, every channel sets cnt_next=phase[i], where phase[i] is the last applied phase (reset 0).
  - Any pending request applies immediately in that cycle.
  - outstb[i] asserts where phase[i]==0.
  - The lock FSM returns to SETTLE.
  - sync_in has priority over normal wrap and apply.
- Undefined: no sync_in port, no realignment logic, and behaviour exactly as above.

Test Plan:
1. rst 4 cycles, then enable=1 with no config -> every outclk toggles each cycle, outstb high every 2nd cycle starting cycle 1, locked=1 after 64 enabled cycles.
2. cfg ch3 div=10 phase=0 -> cfg_ready low until ch3 wrap, then ch3 period 10 with 5 high/5 low, other channels unchanged, locked drops then reasserts 64 cycles later.
3. cfg ch0 div=7 phase=3 -> first post-apply ch0 strobe arrives 4 cycles after apply, then 3 high/4 low every 7 cycles.
4. cfg div=1, then cfg_ch=NUM_CH -> cfg_err pulses once per request, no state change, locked stays 1.
5. Accept ch1 div=20, drop enable for 50 cycles, then assert rst before the wrap -> no apply occurs, cfg_ready=1 after rst, ch1 period 2, locked=0.
6. (CLKGEN_SYNC_ALIGN_EN) ch0 phase 0 and ch1 phase 2 at div 8, pulse sync_in -> next cycle cnt0=0 (strobe) and cnt1=2, offset of 2 is maintained, locked re-settles.
